// File: rtl/fcvt_s_w.sv
// Two-stage integer to binary32 converter (signed/unsigned, round-to-nearest-even).
// S1 takes the magnitude and counts leading zeros; OUT normalizes, rounds and packs.
module fcvt_s_w (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        is_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        inexact
);

    logic        en;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic [31:0] s1_mag_q,   s1_mag_d;
    logic [4:0]  s1_lzc_q,   s1_lzc_d;
    logic        s1_zero_q,  s1_zero_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] y_q,         y_d;
    logic        inexact_q,   inexact_d;

    logic        sign_in;
    logic [31:0] mag_in;
    logic [4:0]  lzc_in;

    logic [30:0] norm;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_res;

    // Whole pipe advances as one; a stalled output freezes both stages.
    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign inexact   = inexact_q;

    always_comb begin
        sign_in = ~is_unsigned & x[31];
        mag_in  = sign_in ? (~x + 32'd1) : x;
        lzc_in  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag_in[i]) lzc_in = 5'(31 - i);
        end

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lzc_d   = s1_lzc_q;
        s1_zero_d  = s1_zero_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_sign_d  = sign_in;
            s1_mag_d   = mag_in;
            s1_lzc_d   = lzc_in;
            s1_zero_d  = (mag_in == 32'd0);
        end
    end

    // The leading one lands in bit 31 and is implicit, so only 31 bits are kept.
    always_comb begin
        norm     = 31'(s1_mag_q << s1_lzc_q);
        guard    = norm[7];
        sticky   = |norm[6:0];
        round_up = guard & (sticky | norm[8]);
        frac_sum = {1'b0, norm[30:8]} + {23'd0, round_up};
        exp_res  = 8'd158 - {3'd0, s1_lzc_q} + {7'd0, frac_sum[23]};

        out_valid_d = out_valid_q;
        y_d         = y_q;
        inexact_d   = inexact_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            y_d         = s1_zero_q ? 32'd0 : {s1_sign_q, exp_res, frac_sum[22:0]};
            inexact_d   = ~s1_zero_q & (guard | sticky);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= 32'd0;
            s1_lzc_q    <= 5'd0;
            s1_zero_q   <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            inexact_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_lzc_q    <= s1_lzc_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            inexact_q   <= inexact_d;
        end
    end

endmodule

// File: doc/fcvt_s_w.md
# fcvt_s_w

Pipelined integer-to-single-precision converter for the FPU: takes a 32-bit signed or unsigned integer and produces an IEEE-754 binary32 result, rounded to nearest-even. It is the producer-side counterpart of the float comparators: those consume binary32 operands and return an integer flag, while this block consumes an integer and returns binary32. It sits in the FPU execute path behind the same valid/ready issue interface as the other multi-cycle FPU units.

## Interface
- Parameters: none.
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- x  in  32  integer operand.
- is_unsigned  in  1  1: x is unsigned (fcvt.s.wu); 0: x is two's-complement (fcvt.s.w).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- y  out  32  binary32 result {sign, exp[7:0], frac[22:0]}.
- inexact  out  1  result was rounded; valid with y.

## Operation
- Transfer on a port occurs when both valid and ready are high at a posedge.
- There are two register stages: S1 and the output stage (OUT).
- Global advance enable: en = ~out_valid | out_ready. in_ready = en, combinational.
- When en is high, both stages shift together: S1 <- input, OUT <- S1. A bubble (valid = 0) propagates as valid = 0.
- When en is low, S1 and OUT hold their contents.
- S1 computation:
  - sign = ~is_unsigned & x[31].
  - mag = sign ? -x : x, as 32-bit unsigned. Signed 0x80000000 gives mag 0x80000000.
  - lzc = count of leading zeros of mag (0..31). lzc is don't-care when mag = 0.
  - zero flag = (mag == 0).
- OUT computation:
  - n = mag << lzc, so n[31] = 1.
  - frac = n[30:8]; guard = n[7]; sticky = |n[6:0].
  - round_up = guard & (sticky | frac[0]).
  - {carry, frac'} = frac + round_up, 24-bit sum.
  - exp = 158 - lzc + carry. When carry is 1, frac' is 0.
  - y = {sign, exp, frac'}.
  - inexact = guard | sticky.
- Zero input: y = 0x00000000 (+0, never -0) and inexact = 0.
- No denormal, infinity or NaN is ever produced. Maximum exp is 159 (2^32).

## Timing
- Reset (rstn = 0 at a posedge):
  - S1 valid and out_valid clear to 0.
  - y clears to 0x00000000 and inexact clears to 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight operands; no result is emitted for them.
- Latency: operand accepted at edge k produces out_valid = 1 after edge k+1, provided en was high at edge k+1.
- Throughput: 1 result per cycle while out_ready = 1.
- Backpressure:
  - While out_valid & ~out_ready, y, inexact and out_valid are held stable and in_ready = 0.
  - At most 2 operands are in flight.
- Simultaneous events:
  - out_ready & in_valid in the same cycle as a full pipe: the output is consumed, S1 moves to OUT, and the new operand enters S1 on the same edge.
  - Holes in the input stream produce holes in out_valid, preserving order.
- is_unsigned is sampled together with x. Per-operand mode switching must work back-to-back.

## Test plan
- Basic signed conversions, back-to-back with out_ready = 1:
  - x = 1 gives 0x3F800000.
  - x = 0xFFFFFFFF signed (-1) gives 0xBF800000.
  - x = 0 gives 0x00000000.
  - All with inexact = 0; results appear on consecutive cycles, each 2 cycles after issue.
- Extremes:
  - Signed 0x80000000 gives 0xCF000000, inexact = 0.
  - Signed 0x7FFFFFFF gives 0x4F000000, inexact = 1 (round-up with mantissa carry).
  - Unsigned 0xFFFFFFFF gives 0x4F800000, inexact = 1.
  - Unsigned 0x80000000 gives 0x4F000000.
- Rounding ties:
  - 16777217 gives 0x4B800000 (tie to even, down), inexact = 1.
  - 16777219 gives 0x4B800002 (tie to even, up).
  - 16777218 gives 0x4B800001, inexact = 0.
- Backpressure:
  - Issue 3 operands with out_ready = 0: in_ready drops after 2 are accepted; y holds the first result stably.
  - Then raise out_ready: all 3 results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-flight: with 2 operands in the pipe, assert rstn = 0 for one edge.
  - Next cycle: out_valid = 0, y = 0, in_ready = 1.
  - No stale result appears afterwards.
- Random regression: 10^5 random x and is_unsigned values with random in_valid and out_ready, checked against a reference model of round-to-nearest-even int-to-float conversion.
